// File: rtl/spi_tx.sv
// -----------------------------------------------------------------------------
// spi_tx -- bit-serial transmitter feeding spi_rx.
//
// Accepts WIDTH-bit words over a valid/ready handshake into a one-word holding
// buffer and shifts them out LSB first, one bit per clock. The holding buffer
// lets a new word be queued while the current frame is shifting, so frames
// can run back to back with no idle cycle between them.
//
// Optional feature (compile-time macro SPI_TX_PARITY_EN):
//   when defined, every frame carries one extra trailing bit equal to the XOR
//   of all data bits (even parity). When undefined, frames are WIDTH bits and
//   no parity logic exists.
//
// Ports:
//   clk          clock, rising edge
//   rst_b        synchronous active-low reset
//   flush        synchronous abort of current frame and holding buffer
//   in_data      word to transmit
//   in_valid     in_data is valid
//   in_ready     holding buffer empty (word accepted on in_valid && in_ready)
//   bit_out      serial data, LSB first, 0 when idle
//   bit_valid    bit_out carries a frame bit this cycle
//   frame_start  high together with bit 0 of each frame
// -----------------------------------------------------------------------------
module spi_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             frame_start
);

`ifdef SPI_TX_PARITY_EN
    localparam int LAST = WIDTH;
`else
    localparam int LAST = WIDTH - 1;
`endif
    localparam int CW = $clog2(LAST + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LAST);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_v_q, hold_v_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bit_out_q, bit_out_d;
    logic             bit_valid_q, bit_valid_d;
    logic             frame_start_q, frame_start_d;
`ifdef SPI_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    logic accept;
    logic load;

    // in_ready comes straight from the register; no path from in_valid.
    assign in_ready = !hold_v_q;
    assign accept   = in_valid && !hold_v_q;

    // Hand the held word to the shifter when idle, or right after the last
    // bit of the current frame so consecutive frames have no gap.
    assign load = hold_v_q &&
                  ((state_q == ST_IDLE) || (cnt_q == CNT_LAST));

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        hold_v_d      = hold_v_q;
        sh_d          = sh_q;
        cnt_d         = cnt_q;
        bit_out_d     = bit_out_q;
        bit_valid_d   = bit_valid_q;
        frame_start_d = frame_start_q;
`ifdef SPI_TX_PARITY_EN
        par_d         = par_q;
`endif

        if (flush) begin
            state_d       = ST_IDLE;
            hold_v_d      = 1'b0;
            cnt_d         = '0;
            bit_out_d     = 1'b0;
            bit_valid_d   = 1'b0;
            frame_start_d = 1'b0;
        end else begin
            // accept and load are mutually exclusive: one needs hold_v=0,
            // the other hold_v=1.
            if (accept) begin
                hold_d   = in_data;
                hold_v_d = 1'b1;
            end

            if (load) begin
                sh_d          = hold_q;
                hold_v_d      = 1'b0;
                cnt_d         = '0;
                state_d       = ST_SHIFT;
                bit_out_d     = hold_q[0];
                bit_valid_d   = 1'b1;
                frame_start_d = 1'b1;
`ifdef SPI_TX_PARITY_EN
                par_d         = ^hold_q;
`endif
            end else if (state_q == ST_SHIFT) begin
                if (cnt_q == CNT_LAST) begin
                    state_d       = ST_IDLE;
                    cnt_d         = '0;
                    bit_out_d     = 1'b0;
                    bit_valid_d   = 1'b0;
                    frame_start_d = 1'b0;
                end else begin
                    // sh_q[0] is the bit currently on the line, so the next
                    // bit is always sh_q[1] before the shift.
                    cnt_d         = cnt_q + CW'(1);
                    sh_d          = sh_q >> 1;
                    bit_out_d     = sh_q[1];
                    frame_start_d = 1'b0;
`ifdef SPI_TX_PARITY_EN
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        bit_out_d = par_q;
                    end
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q       <= ST_IDLE;
            hold_q        <= '0;
            hold_v_q      <= 1'b0;
            sh_q          <= '0;
            cnt_q         <= '0;
            bit_out_q     <= 1'b0;
            bit_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
`ifdef SPI_TX_PARITY_EN
            par_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            hold_v_q      <= hold_v_d;
            sh_q          <= sh_d;
            cnt_q         <= cnt_d;
            bit_out_q     <= bit_out_d;
            bit_valid_q   <= bit_valid_d;
            frame_start_q <= frame_start_d;
`ifdef SPI_TX_PARITY_EN
            par_q         <= par_d;
`endif
        end
    end

    assign bit_out     = bit_out_q;
    assign bit_valid   = bit_valid_q;
    assign frame_start = frame_start_q;

endmodule

// File: doc/spi_tx.md
Name: spi_tx

Overview:
- Serializer that is the transmit end of the bit-serial byte link whose receiver is `spi_rx`.
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock, LSB first.
- A one-word holding buffer allows back-to-back frames with no idle cycle between them.
- Sits between the byte producer and the serial line feeding `spi_rx`.

Parameters:
- WIDTH, 8, data bits per frame; legal values are 2..32.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_b  input  1  reset, synchronous, active-low.
- flush  input  1  synchronous, active-high abort of the current frame and the holding buffer.
- in_data  input  WIDTH  word to transmit.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  holding buffer is empty; a word is accepted on an edge where in_valid && in_ready.
- bit_out  output  1  serial data, LSB first; 0 when idle.
- bit_valid  output  1  bit_out carries a frame bit this cycle.
- frame_start  output  1  high together with bit 0 of each frame.

Behaviour:
- Reset (rst_b=0 at an edge):
  - bit_out=0, bit_valid=0, frame_start=0, in_ready=1.
  - Holding buffer empty, shifter empty, bit counter 0, state IDLE.
  - Reset dominates flush and in_valid, including mid-frame; a partial frame is dropped with no trailing bits.
- Registers:
  - hold[WIDTH-1:0] with hold_v.
  - sh[WIDTH-1:0].
  - cnt, 0..WIDTH-1 (0..WIDTH when parity is enabled).
  - state in {IDLE, SHIFT}.
- Handshake:
  - in_ready = !hold_v, taken directly from the register with no combinational path from in_valid.
  - On an accept edge: hold <= in_data, hold_v <= 1.
  - in_data is ignored when not accepted.
- IDLE:
  - With hold_v=1 at an edge: sh <= hold, hold_v <= 0, cnt <= 0, state <= SHIFT.
  - bit_out <= hold[0], bit_valid <= 1, frame_start <= 1.
  - Latency: a word accepted at edge N drives its bit 0 during the cycle after edge N+1.
- SHIFT:
  - Each edge advances one bit: cnt <= cnt+1, bit_out <= next bit, frame_start <= 0.
  - After the last bit's cycle (cnt==WIDTH-1), at the next edge:
    - If hold_v=1: load the next word as in IDLE (frame_start=1, zero gap). An accept on that same edge is impossible because in_ready=0.
    - Otherwise: state <= IDLE, bit_valid <= 0, bit_out <= 0.
  - A word may be accepted into hold during any SHIFT cycle while hold_v=0.
- flush=1 at an edge:
  - state <= IDLE, hold_v <= 0, cnt <= 0, bit_valid/frame_start/bit_out <= 0.
  - in_valid on that edge is not accepted.
  - in_ready=1 from the following cycle.
  - flush held for several cycles keeps the block idle.
- Bit order: bit i of the word appears on bit_out in the i-th valid cycle of the frame (i=0 first).
- Outputs are registered only; the serial outputs have no combinational path from inputs.

Optional Feature:
- Macro: SPI_TX_PARITY_EN.
- Defined:
  - Each frame is WIDTH+1 bits. The extra bit follows bit WIDTH-1 and equals the XOR of all data bits (even parity).
  - bit_valid stays high for the parity bit; frame_start is unchanged.
  - The hold-to-shifter handover occurs after the parity bit.
- Undefined: frames are exactly WIDTH bits and no parity logic is present.

Test Plan:
- Reset then single word, WIDTH=8: in_data=0x53 for one cycle → after 2-cycle latency, bit_out = 1,1,0,0,1,0,1,0 over 8 bit_valid cycles, frame_start only on the first, then bit_out=0 and bit_valid=0.
- Back-to-back: in_valid held with 0x53 then 0xFC → 16 consecutive bit_valid cycles (1,1,0,0,1,0,1,0, 0,0,1,1,1,1,1,1), frame_start at cycles 1 and 9, and in_ready low while hold is full.
- Flush mid-frame: send 0xFF, assert flush after 3 bits → bit_valid=0 on the next cycle and in_ready=1. Then sending 0xE5 yields 1,0,1,0,0,1,1,1 with frame_start on its first bit.
- Reset mid-frame: rst_b=0 for one edge during bit 4 of 0xA5 with hold loaded → all outputs reach their reset values, nothing further is transmitted, and in_ready=1.
- in_valid with flush on the same edge: 0x3C presented with flush=1 → not accepted; no bits are ever transmitted for 0x3C.
- SPI_TX_PARITY_EN: 0x53 → 9 bits, last bit 0. Then 0xE5 → 9 bits, last bit 1. The two frames are contiguous with no gap.
